// File: rtl/prefix_sub_pkg.sv
// Shared definitions for the pipelined Kogge-Stone add/subtract lane:
// op encoding, result flag bundle and pipeline sizing helpers.
package prefix_sub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic carry_out;
        logic zero;
        logic negative;
        logic overflow;
    } flags_t;

    function automatic int prefix_levels(input int width);
        return $clog2(width);
    endfunction

    function automatic int prefix_stages(input int levels, input int lps);
        return (levels + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/prefix_level.sv
// One Kogge-Stone prefix level: combines each bit's group generate/propagate
// with the group SPAN bits below; bits below SPAN pass through.
module prefix_level #(
    parameter int WIDTH = 64,
    parameter int SPAN  = 1
) (
    input  logic [WIDTH-1:0] i_g,
    input  logic [WIDTH-1:0] i_pp,
    output logic [WIDTH-1:0] o_g,
    output logic [WIDTH-1:0] o_pp
);

    always_comb begin
        o_g  = i_g;
        o_pp = i_pp;
        for (int i = SPAN; i < WIDTH; i++) begin
            o_g[i]  = i_g[i] | (i_pp[i] & i_g[i-SPAN]);
            o_pp[i] = i_pp[i] & i_pp[i-SPAN];
        end
    end

endmodule

// File: rtl/prefix_sub_pipe.sv
// Pipelined Kogge-Stone add/subtract lane with elastic valid/ready handshake.
// Optional signed saturation on overflow: define PREFIX_SUB_SATURATE_EN.
module prefix_sub_pipe
    import prefix_sub_pkg::*;
#(
    parameter int WIDTH            = 64,
    parameter int LEVELS_PER_STAGE = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow
`ifdef PREFIX_SUB_SATURATE_EN
    ,
    input  logic             sat
`endif
);

    localparam int LEVELS = prefix_levels(WIDTH);
    localparam int STAGES = prefix_stages(LEVELS, LEVELS_PER_STAGE);

    logic             w_adv;
    logic [WIDTH-1:0] w_b, w_p0, w_g0;
    logic             w_cin;

    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_g   [STAGES];
    logic [WIDTH-1:0] r_pp  [STAGES];
    logic [WIDTH-1:0] r_p   [STAGES];
    logic             r_cin [STAGES];
`ifdef PREFIX_SUB_SATURATE_EN
    logic             r_sat [STAGES];
`endif

    logic [WIDTH-1:0] w_gi [LEVELS];
    logic [WIDTH-1:0] w_ppi [LEVELS];
    logic [WIDTH-1:0] w_go [LEVELS];
    logic [WIDTH-1:0] w_ppo [LEVELS];
    logic [WIDTH-1:0] w_grp_g [STAGES];
    logic [WIDTH-1:0] w_grp_pp [STAGES];

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    flags_t           r_flags;

    // The whole pipe freezes while a result waits for its consumer.
    assign w_adv    = !(r_out_valid && !out_ready);
    assign in_ready = w_adv;

    // Stage 0: operand conditioning; carry-in is folded into bit-0 generate.
    always_comb begin
        w_b     = (op_sub == OP_ADD) ? operand_b : ~operand_b;
        w_cin   = (op_sub == OP_SUB);
        w_p0    = operand_a ^ w_b;
        w_g0    = operand_a & w_b;
        w_g0[0] = w_g0[0] | (w_p0[0] & w_cin);
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        if (k % LEVELS_PER_STAGE == 0) begin : g_head
            assign w_gi[k]  = r_g[k / LEVELS_PER_STAGE];
            assign w_ppi[k] = r_pp[k / LEVELS_PER_STAGE];
        end else begin : g_chain
            assign w_gi[k]  = w_go[k-1];
            assign w_ppi[k] = w_ppo[k-1];
        end
        prefix_level #(.WIDTH(WIDTH), .SPAN(1 << k)) u_level (
            .i_g  (w_gi[k]),
            .i_pp (w_ppi[k]),
            .o_g  (w_go[k]),
            .o_pp (w_ppo[k])
        );
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_grp
        localparam int LAST = ((j + 1) * LEVELS_PER_STAGE < LEVELS) ?
                              (j + 1) * LEVELS_PER_STAGE - 1 : LEVELS - 1;
        assign w_grp_g[j]  = w_go[LAST];
        assign w_grp_pp[j] = w_ppo[LAST];
    end

    // Data registers: loaded on advance, never cleared.
    always_ff @(posedge clock) begin
        if (w_adv) begin
            if (in_valid) begin
                r_g[0]   <= w_g0;
                r_pp[0]  <= w_p0;
                r_p[0]   <= w_p0;
                r_cin[0] <= w_cin;
`ifdef PREFIX_SUB_SATURATE_EN
                r_sat[0] <= sat;
`endif
            end
            for (int s = 1; s < STAGES; s++) begin
                r_g[s]   <= w_grp_g[s-1];
                r_pp[s]  <= w_grp_pp[s-1];
                r_p[s]   <= r_p[s-1];
                r_cin[s] <= r_cin[s-1];
`ifdef PREFIX_SUB_SATURATE_EN
                r_sat[s] <= r_sat[s-1];
`endif
            end
        end
    end

    // Final stage: sum from resolved carries, flags, optional clamp.
    logic [WIDTH-1:0] w_gf, w_c, w_sum, w_result;
    logic             w_ovf;
    flags_t           w_flags;

`ifdef PREFIX_SUB_SATURATE_EN
    function automatic logic [WIDTH-1:0] sat_clamp(input logic [WIDTH-1:0] sum,
                                                   input logic ovf, input logic en);
        if (en && ovf)
            return sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        return sum;
    endfunction
`endif

    always_comb begin
        w_gf  = w_grp_g[STAGES-1];
        w_c   = {w_gf[WIDTH-2:0], r_cin[STAGES-1]};
        w_sum = r_p[STAGES-1] ^ w_c;
        w_ovf = w_c[WIDTH-1] ^ w_gf[WIDTH-1];
`ifdef PREFIX_SUB_SATURATE_EN
        w_result = sat_clamp(w_sum, w_ovf, r_sat[STAGES-1]);
`else
        w_result = w_sum;
`endif
        w_flags.carry_out = w_gf[WIDTH-1];
        w_flags.zero      = (w_result == '0);
        w_flags.negative  = w_result[WIDTH-1];
        w_flags.overflow  = w_ovf;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) r_vld[s] <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            for (int s = 1; s < STAGES; s++) r_vld[s] <= r_vld[s-1];
            r_out_valid <= r_vld[STAGES-1];
            if (r_vld[STAGES-1]) begin
                r_result <= w_result;
                r_flags  <= w_flags;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry_out = r_flags.carry_out;
    assign zero      = r_flags.zero;
    assign negative  = r_flags.negative;
    assign overflow  = r_flags.overflow;

endmodule
